// File: rtl/out_projection_if.sv
// ---------------------------------------------------------------------------
// out_projection_if
//
// Bundles the control, input-stream, weight-memory and output-stream signals
// of the out_projection block so they travel as one port.
//
// Parameters
//   WIDTH    data / weight word width
//   D_MODEL  vector length; sets the weight address width
//
// Signals
//   init, ready                 start request / idle indication
//   in_valid, in_ready, in_data concatenated-heads input stream
//   w_addr, w_data              weight memory read port (1-cycle latency)
//   out_valid, out_ready,
//   out_data                    projected output stream
//
// Modports
//   slave   the projection block
//   master  the environment driving it (controller, source, memory, sink)
// ---------------------------------------------------------------------------
interface out_projection_if #(
   parameter int WIDTH   = 32,
   parameter int D_MODEL = 8
);
   localparam int AW = $clog2(D_MODEL * D_MODEL);

   logic             init;
   logic             ready;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [AW-1:0]    w_addr;
   logic [WIDTH-1:0] w_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport slave (
      input  init,
      input  in_valid,
      input  in_data,
      input  w_data,
      input  out_ready,
      output ready,
      output in_ready,
      output w_addr,
      output out_valid,
      output out_data
   );

   modport master (
      output init,
      output in_valid,
      output in_data,
      output w_data,
      output out_ready,
      input  ready,
      input  in_ready,
      input  w_addr,
      input  out_valid,
      input  out_data
   );
endinterface

// File: rtl/out_projection.sv
// ---------------------------------------------------------------------------
// out_projection
//
// Output projection of an attention layer: y = W * x, where x is the
// concatenation of all head outputs (D_MODEL elements) and W is a
// D_MODEL x D_MODEL weight matrix held in an external memory.
//
// Operation
//   IDLE : ready=1, waits for an init pulse.
//   LOAD : accepts D_MODEL elements of x into a local buffer.
//   MAC  : for row r, streams W[r][0..D_MODEL-1] out of the memory and
//          accumulates x[k]*W[r][k] with full precision. D_MODEL+1 cycles,
//          because memory data lags the address by one cycle.
//   EMIT : presents y[r] (accumulator >>> FRAC, saturated to WIDTH bits)
//          until the consumer accepts it, then moves to the next row or
//          back to IDLE after the last row.
//
// Parameters
//   WIDTH    signed fixed-point word width of x, W and y
//   FRAC     fractional bits of the fixed-point format
//   D_MODEL  vector length, 2..64
//
// Ports
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   bus      out_projection_if.slave (init/ready, input stream, weight
//            read port, output stream); the connected interface instance
//            must use the same WIDTH and D_MODEL
// ---------------------------------------------------------------------------
module out_projection #(
   parameter int WIDTH   = 32,
   parameter int FRAC    = 16,
   parameter int D_MODEL = 8
) (
   input  logic               clk,
   input  logic               reset,
   out_projection_if.slave    bus
);

   localparam int IDXW  = $clog2(D_MODEL);
   localparam int AW    = $clog2(D_MODEL * D_MODEL);
   localparam int PRODW = 2 * WIDTH;
   // Headroom of IDXW bits lets D_MODEL full-scale products sum without wrap.
   localparam int ACCW  = PRODW + IDXW;

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(D_MODEL - 1);
   // MAC step counter runs 0..D_MODEL; the final step only retires the
   // last memory read and issues no address.
   localparam logic [IDXW:0]   MAC_LAST = (IDXW + 1)'(D_MODEL);

   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH - 1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      MAC  = 2'd2,
      EMIT = 2'd3
   } state_t;

   state_t state;
   state_t next_state;

   logic [IDXW-1:0]         load_cnt;
   logic [IDXW-1:0]         r;
   logic [IDXW:0]           k;
   logic [IDXW-1:0]         k_d;
   logic signed [ACCW-1:0]  acc;
   logic signed [WIDTH-1:0] x_buf [D_MODEL];

   logic                    load_fire;
   logic                    load_done;
   logic                    mac_done;
   logic                    emit_fire;
   logic                    addr_phase;

   logic signed [WIDTH-1:0] x_sel;
   logic signed [PRODW-1:0] x_ext;
   logic signed [PRODW-1:0] w_ext;
   logic signed [PRODW-1:0] prod;
   logic signed [ACCW-1:0]  prod_ext;
   logic signed [ACCW-1:0]  acc_sh;
   logic [ACCW-WIDTH:0]     acc_top;
   logic                    fits;
   logic [WIDTH-1:0]        sat_data;

   assign load_fire  = (state == LOAD) && bus.in_valid;
   assign load_done  = load_fire && (load_cnt == LAST_IDX);
   assign mac_done   = (state == MAC) && (k == MAC_LAST);
   assign emit_fire  = (state == EMIT) && bus.out_ready;
   assign addr_phase = (state == MAC) && (k != MAC_LAST);

   // The weight word arriving now belongs to the address issued one cycle
   // ago, so x is indexed with the delayed step k_d. Both operands are sign
   // extended to the full product width before multiplying.
   assign x_sel    = x_buf[k_d];
   assign x_ext    = {{WIDTH{x_sel[WIDTH-1]}}, x_sel};
   assign w_ext    = {{WIDTH{bus.w_data[WIDTH-1]}}, bus.w_data};
   assign prod     = x_ext * w_ext;
   assign prod_ext = {{IDXW{prod[PRODW-1]}}, prod};

   // Arithmetic shift floors toward minus infinity; the result fits in WIDTH
   // bits only when every bit from the WIDTH-1 position upward matches the
   // sign, otherwise it clamps to the nearest representable extreme.
   assign acc_sh   = acc >>> FRAC;
   assign acc_top  = acc_sh[ACCW-1:WIDTH-1];
   assign fits     = (&acc_top) | ~(|acc_top);
   assign sat_data = fits ? acc_sh[WIDTH-1:0]
                          : (acc_sh[ACCW-1] ? SAT_MIN : SAT_MAX);

   // State register; reset wins over every other input in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode and all block outputs. Every output defaults to its
   // idle value so each state only raises what it owns; out_data comes
   // straight from the accumulator, which is frozen while in EMIT, so it
   // stays stable under backpressure.
   always_comb begin
      next_state    = state;
      bus.ready     = 1'b0;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.w_addr    = '0;
      bus.out_data  = '0;

      unique case (state)
         IDLE: begin
            bus.ready = 1'b1;
            if (bus.init) begin
               next_state = LOAD;
            end
         end

         LOAD: begin
            bus.in_ready = 1'b1;
            if (load_done) begin
               next_state = MAC;
            end
         end

         MAC: begin
            if (addr_phase) begin
               bus.w_addr = AW'(r) * AW'(D_MODEL) + AW'(k[IDXW-1:0]);
            end
            if (mac_done) begin
               next_state = EMIT;
            end
         end

         EMIT: begin
            bus.out_valid = 1'b1;
            bus.out_data  = sat_data;
            if (bus.out_ready) begin
               next_state = (r == LAST_IDX) ? IDLE : MAC;
            end
         end

         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Counters and accumulator. The accumulator is cleared on every path into
   // MAC (end of LOAD, each EMIT handshake) so each row starts from zero.
   // During MAC the first step only issues an address; the following
   // D_MODEL steps each retire one product.
   always_ff @(posedge clk) begin
      if (reset) begin
         load_cnt <= '0;
         r        <= '0;
         k        <= '0;
         k_d      <= '0;
         acc      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               load_cnt <= '0;
               r        <= '0;
               k        <= '0;
               acc      <= '0;
            end

            LOAD: begin
               if (load_done) begin
                  load_cnt <= '0;
                  r        <= '0;
                  k        <= '0;
                  acc      <= '0;
               end else if (load_fire) begin
                  load_cnt <= load_cnt + 1'b1;
               end
            end

            MAC: begin
               k_d <= k[IDXW-1:0];
               if (k != '0) begin
                  acc <= acc + prod_ext;
               end
               if (mac_done) begin
                  k <= '0;
               end else begin
                  k <= k + 1'b1;
               end
            end

            EMIT: begin
               if (emit_fire) begin
                  k   <= '0;
                  acc <= '0;
                  if (r == LAST_IDX) begin
                     r <= '0;
                  end else begin
                     r <= r + 1'b1;
                  end
               end
            end

            default: begin
               load_cnt <= '0;
               r        <= '0;
               k        <= '0;
               acc      <= '0;
            end
         endcase
      end
   end

   // Input vector buffer. Written only by a LOAD handshake, so in_valid in
   // any other state leaves x untouched. No reset: contents are always
   // fully rewritten before they are used.
   always_ff @(posedge clk) begin
      if (!reset && load_fire) begin
         x_buf[load_cnt] <= bus.in_data;
      end
   end

endmodule

// File: tb/tb_out_projection.sv
// ---------------------------------------------------------------------------
// tb_out_projection
//
// Directed bench for out_projection at WIDTH=32, FRAC=16, D_MODEL=4.
// Weights live in a local array that answers w_addr one cycle later.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_out_projection;

   localparam int WIDTH   = 32;
   localparam int FRAC    = 16;
   localparam int D_MODEL = 4;
   localparam int NW      = D_MODEL * D_MODEL;

   logic clk = 1'b0;
   logic reset;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   out_projection_if #(.WIDTH(WIDTH), .D_MODEL(D_MODEL)) bus ();

   out_projection #(
      .WIDTH   (WIDTH),
      .FRAC    (FRAC),
      .D_MODEL (D_MODEL)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [WIDTH-1:0] wmem [NW];

   // Weight memory with one cycle of read latency.
   always @(posedge clk) begin
      bus.w_data <= wmem[bus.w_addr];
   end

   // Identity matrix, diagonal = 1.0
   logic [WIDTH-1:0] w_ident [NW] = '{
      32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
      32'h0000_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000,
      32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000,
      32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0001_0000};

   // row0 {0.5,1,0,0}  row1 {0,0,-1,2}  row2 {1,1,1,1}
   // row3 {-0.5,0,0,-2^-16}
   logic [WIDTH-1:0] w_gen [NW] = '{
      32'h0000_8000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0000,
      32'h0000_0000, 32'h0000_0000, 32'hFFFF_0000, 32'h0002_0000,
      32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
      32'hFFFF_8000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};

   logic [WIDTH-1:0] w_max [NW] = '{default: 32'h7FFF_0000};

   // x = {1.0, 2.0, -3.0, 0.5}
   logic [WIDTH-1:0] x_ident [D_MODEL] = '{
      32'h0001_0000, 32'h0002_0000, 32'hFFFD_0000, 32'h0000_8000};
   logic [WIDTH-1:0] x_max [D_MODEL] = '{default: 32'h7FFF_0000};
   logic [WIDTH-1:0] x_neg [D_MODEL] = '{default: 32'h8001_0000};

   logic [WIDTH-1:0] y_ident [D_MODEL] = '{
      32'h0001_0000, 32'h0002_0000, 32'hFFFD_0000, 32'h0000_8000};
   // 2.5, 4.0, 0.5, floor(-0.5 - 2^-17) = -0.5 - 2^-16
   logic [WIDTH-1:0] y_gen [D_MODEL] = '{
      32'h0002_8000, 32'h0004_0000, 32'h0000_8000, 32'hFFFF_7FFF};
   logic [WIDTH-1:0] y_max [D_MODEL] = '{default: 32'h7FFF_FFFF};
   logic [WIDTH-1:0] y_min [D_MODEL] = '{default: 32'h8000_0000};

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_output(input string tag,
                               input logic [WIDTH-1:0] obs,
                               input logic [WIDTH-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Pulse init from IDLE and stream x with in_valid held high. Returns on
   // the falling edge just after the last element was accepted, which is
   // the first MAC cycle of row 0.
   task automatic apply_stimulus(input logic [WIDTH-1:0] xv [D_MODEL]);
      bus.init = 1'b1;
      tick();
      bus.init = 1'b0;
      for (int i = 0; i < D_MODEL; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = xv[i];
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_out_valid(input string tag);
      int n = 0;
      while (bus.out_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check_bit({tag, "_valid"}, bus.out_valid, 1'b1);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (bus.ready !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      check_bit({tag, "_ready"}, bus.ready, 1'b1);
   endtask

   // Accept rows first_row..D_MODEL-1 with out_ready high, then expect IDLE.
   task automatic drain_rows(input logic [WIDTH-1:0] yv [D_MODEL],
                             input int first_row, input string tag);
      bus.out_ready = 1'b1;
      for (int rr = first_row; rr < D_MODEL; rr++) begin
         wait_out_valid($sformatf("%s_r%0d", tag, rr));
         check_output($sformatf("%s_y%0d", tag, rr), bus.out_data, yv[rr]);
         tick();
      end
      wait_ready(tag);
   endtask

   task automatic run_projection(input logic [WIDTH-1:0] xv [D_MODEL],
                                 input logic [WIDTH-1:0] yv [D_MODEL],
                                 input string tag);
      apply_stimulus(xv);
      drain_rows(yv, 0, tag);
   endtask

   initial begin
      int n;
      int rr;
      int cc;

      wmem          = w_ident;
      reset         = 1'b1;
      bus.init      = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hDEAD_BEEF;
      bus.out_ready = 1'b1;
      $display("[TB] start");

      // Reset held with init and in_valid high: reset must win.
      tick();
      tick();
      tick();
      check_bit("rst_ready", bus.ready, 1'b1);
      check_bit("rst_in_ready", bus.in_ready, 1'b0);
      check_bit("rst_out_valid", bus.out_valid, 1'b0);
      check_output("rst_out_data", bus.out_data, '0);
      check_output("rst_w_addr", WIDTH'(bus.w_addr), '0);

      reset        = 1'b0;
      bus.init     = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      check_bit("idle_ready", bus.ready, 1'b1);

      // Identity projection with cycle-exact timing. init is pulsed again
      // mid-LOAD and must be ignored.
      bus.init = 1'b1;
      tick();
      bus.init = 1'b0;
      check_bit("load_ready", bus.ready, 1'b0);
      check_bit("load_in_ready", bus.in_ready, 1'b1);
      for (int i = 0; i < D_MODEL; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = x_ident[i];
         bus.init     = (i == 2);
         tick();
      end
      bus.init     = 1'b0;
      bus.in_valid = 1'b0;
      check_bit("mac_in_ready", bus.in_ready, 1'b0);
      // Cycle i counts falling edges after the last input handshake.
      for (int i = 1; i <= 25; i++) begin
         if (i > 1) tick();
         rr = (i - 1) / 6;
         cc = (i - 1) % 6;
         check_bit($sformatf("id_valid_c%0d", i), bus.out_valid,
                   (i % 6 == 0) && (i <= 24));
         check_bit($sformatf("id_ready_c%0d", i), bus.ready, i == 25);
         if (i <= 24) begin
            check_output($sformatf("id_addr_c%0d", i), WIDTH'(bus.w_addr),
                         (cc < 4) ? WIDTH'(rr * 4 + cc) : '0);
         end
         if ((i % 6 == 0) && (i <= 24)) begin
            check_output($sformatf("id_y%0d", rr), bus.out_data, y_ident[rr]);
         end
      end

      // Saturation in both directions.
      wmem = w_max;
      run_projection(x_max, y_max, "sat_pos");
      run_projection(x_neg, y_min, "sat_neg");

      // General matrix with a fractional result that must floor.
      wmem = w_gen;
      run_projection(x_ident, y_gen, "gen");

      // Backpressure on row 1 with junk in_valid outside LOAD.
      wmem          = w_ident;
      bus.out_ready = 1'b0;
      apply_stimulus(x_ident);
      wait_out_valid("bp_r0");
      check_output("bp_y0", bus.out_data, y_ident[0]);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h1234_5678;
      wait_out_valid("bp_r1");
      for (int j = 0; j < 5; j++) begin
         check_bit($sformatf("bp_hold_valid%0d", j), bus.out_valid, 1'b1);
         check_output($sformatf("bp_hold_y1_%0d", j), bus.out_data, y_ident[1]);
         check_output($sformatf("bp_hold_addr%0d", j), WIDTH'(bus.w_addr), '0);
         tick();
      end
      check_output("bp_still_y1", bus.out_data, y_ident[1]);
      bus.out_ready = 1'b1;
      tick();
      check_bit("bp_r2_mac_valid", bus.out_valid, 1'b0);
      check_output("bp_r2_addr", WIDTH'(bus.w_addr), 32'd8);
      drain_rows(y_ident, 2, "bp");
      bus.in_valid = 1'b0;
      tick();

      // Reset during MAC of row 2, then a clean projection.
      wmem = w_gen;
      apply_stimulus(x_ident);
      n = 0;
      while (bus.w_addr !== 4'd8 && n < 40) begin
         tick();
         n++;
      end
      check_output("rmac_reach", WIDTH'(bus.w_addr), 32'd8);
      reset = 1'b1;
      tick();
      check_bit("rmac_ready", bus.ready, 1'b1);
      check_bit("rmac_out_valid", bus.out_valid, 1'b0);
      check_bit("rmac_in_ready", bus.in_ready, 1'b0);
      check_output("rmac_addr", WIDTH'(bus.w_addr), '0);
      reset = 1'b0;
      tick();
      run_projection(x_ident, y_gen, "post_rmac");

      // Reset mid-LOAD after two elements.
      bus.init = 1'b1;
      tick();
      bus.init     = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h7FFF_0000;
      tick();
      tick();
      reset = 1'b1;
      tick();
      check_bit("rload_ready", bus.ready, 1'b1);
      check_bit("rload_in_ready", bus.in_ready, 1'b0);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      tick();
      run_projection(x_ident, y_gen, "post_rload");

      // Reset mid-EMIT of row 0.
      bus.out_ready = 1'b0;
      apply_stimulus(x_ident);
      wait_out_valid("remit");
      check_output("remit_y0", bus.out_data, y_gen[0]);
      reset = 1'b1;
      tick();
      check_bit("remit_out_valid", bus.out_valid, 1'b0);
      check_output("remit_out_data", bus.out_data, '0);
      check_bit("remit_ready", bus.ready, 1'b1);
      reset         = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      run_projection(x_ident, y_gen, "post_remit");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
